// File: rtl/arch_state_dumper.sv
// Purpose: walks the register file and then the first data-memory words, emitting one tagged word per cycle.
// Latency: busy from the request edge, first word valid one edge later, one word per cycle after that.
// Backpressure: output register holds data, tag, index and read addresses while valid && !ready.
//
// Ports:
//   clk_i, rst_i              CPU clock, asynchronous active-high reset
//   dump_req_i                start request (ignored while busy_o)
//   busy_o / cpu_hold_o       dump in progress; CPU pipeline frozen while high
//   done_o                    one-cycle pulse after the final word's handshake
//   reg_addr_o / reg_data_i   register-file read port (combinational data)
//   mem_addr_o / mem_data_i   data-memory read port, word-aligned byte address
//   out_valid_o / out_ready_i / out_data_o / out_tag_o   tagged output stream
//
// Optional feature: define DUMP_CYCLE_STAMP_EN to add a 16-bit free-running cycle
// counter and a header word (tag 0xFF) carrying the counter value at the request edge.
module arch_state_dumper #(
    parameter int NUM_REGS      = 32,
    parameter int NUM_MEM_WORDS = 8,
    parameter int DATA_W        = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              dump_req_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              cpu_hold_o,
    output logic [4:0]        reg_addr_o,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic [31:0]       mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [7:0]        out_tag_o
);

    localparam int MAX_IDX = (NUM_REGS > NUM_MEM_WORDS) ? NUM_REGS : NUM_MEM_WORDS;
    localparam int IDX_W   = $clog2(MAX_IDX) + 1;
    localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(NUM_MEM_WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

`ifdef DUMP_CYCLE_STAMP_EN
    typedef enum logic [1:0] {IDLE, REG, MEM, HDR} state_t;
`else
    typedef enum logic [1:0] {IDLE, REG, MEM} state_t;
`endif

    state_t           state;
    logic [IDX_W-1:0] idx;
    // Set once the last memory word is in the output register; the FSM then only waits for its handshake.
    logic             drain;
    logic             out_load;
    logic             out_hs;

    assign out_load   = !out_valid_o || out_ready_i;
    assign out_hs     = out_valid_o && out_ready_i;
    assign cpu_hold_o = busy_o;

    // Read addresses follow the index only in their own phase, 0 otherwise.
    always_comb begin
        reg_addr_o = '0;
        mem_addr_o = '0;
        if (state == REG) reg_addr_o = 5'(idx);
        if (state == MEM) mem_addr_o = 32'(idx) << 2;
    end

`ifdef DUMP_CYCLE_STAMP_EN
    logic [15:0] cycle_cnt;
    logic [15:0] stamp;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cycle_cnt <= '0;
        else       cycle_cnt <= cycle_cnt + 16'd1;
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            idx         <= '0;
            drain       <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_tag_o   <= '0;
`ifdef DUMP_CYCLE_STAMP_EN
            stamp       <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (dump_req_i) begin
                        idx    <= '0;
                        drain  <= 1'b0;
                        busy_o <= 1'b1;
`ifdef DUMP_CYCLE_STAMP_EN
                        stamp  <= cycle_cnt;
                        state  <= HDR;
`else
                        state  <= REG;
`endif
                    end
                end
`ifdef DUMP_CYCLE_STAMP_EN
                HDR: begin
                    if (out_load) begin
                        out_valid_o <= 1'b1;
                        out_data_o  <= DATA_W'({16'h0000, stamp});
                        out_tag_o   <= 8'hFF;
                        state       <= REG;
                    end
                end
`endif
                REG: begin
                    if (out_load) begin
                        out_valid_o <= 1'b1;
                        out_data_o  <= reg_data_i;
                        out_tag_o   <= 8'(idx);
                        if (idx == LAST_REG) begin
                            idx   <= '0;
                            state <= MEM;
                        end else begin
                            idx <= idx + IDX_ONE;
                        end
                    end
                end
                MEM: begin
                    if (!drain) begin
                        if (out_load) begin
                            out_valid_o <= 1'b1;
                            out_data_o  <= mem_data_i;
                            out_tag_o   <= 8'h80 + 8'(idx);
                            if (idx == LAST_MEM) drain <= 1'b1;
                            else                 idx   <= idx + IDX_ONE;
                        end
                    end else if (out_hs) begin
                        out_valid_o <= 1'b0;
                        drain       <= 1'b0;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
